// File: rtl/regfile_mp_fwd_pkg.sv
// Package for the multi-port forwarding register file.
// Holds the reset/enable level constants shared by the top and the read-port
// sub-module. Width parameters are not defined here. They stay module
// parameters so several differently sized instances can coexist.
package regfile_mp_fwd_pkg;

    // rst is active-low.
    localparam logic RSTN_ENABLE  = 1'b0;
    localparam logic RSTN_DISABLE = 1'b1;

    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic READ_ENABLE  = 1'b1;

endpackage

// File: rtl/regfile_mp_fwd_if.sv
// Bus interface for regfile_mp_fwd.
// Groups the write-back port, the forwarding-stage ports, the read ports, the
// scoreboard controls and the status outputs.
//   slave  : register-file side (design)
//   master : pipeline side (driver)
// Handshake: there is no valid/ready pairing here. Every input is sampled on the
// rising clk edge or used combinationally in the same cycle. rdata_o and stall_o
// are pure functions of the current inputs and the stored state.
interface regfile_mp_fwd_if #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2,
    parameter int NFWD = 2
);
    logic [DW-1:0]       wb_inst_i;
    logic                wb_we_i;
    logic [AW-1:0]       wb_waddr_i;
    logic [DW-1:0]       wb_wdata_i;
    logic                wb_long_i;
    logic [NFWD-1:0]     fwd_we_i;
    logic [NFWD-1:0]     fwd_valid_i;
    logic [NFWD*AW-1:0]  fwd_waddr_i;
    logic [NFWD*DW-1:0]  fwd_wdata_i;
    logic [NRD-1:0]      re_i;
    logic [NRD*AW-1:0]   raddr_i;
    logic [NRD*DW-1:0]   rdata_o;
    logic                sb_set_i;
    logic [AW-1:0]       sb_set_addr_i;
    logic                sb_flush_i;
    logic [(2**AW)-1:0]  busy_o;
    logic                stall_o;
    logic [DW-1:0]       dbg_inst_o;

    modport slave (
        input  wb_inst_i, wb_we_i, wb_waddr_i, wb_wdata_i, wb_long_i,
        input  fwd_we_i, fwd_valid_i, fwd_waddr_i, fwd_wdata_i,
        input  re_i, raddr_i,
        input  sb_set_i, sb_set_addr_i, sb_flush_i,
        output rdata_o, busy_o, stall_o, dbg_inst_o
    );

    modport master (
        output wb_inst_i, wb_we_i, wb_waddr_i, wb_wdata_i, wb_long_i,
        output fwd_we_i, fwd_valid_i, fwd_waddr_i, fwd_wdata_i,
        output re_i, raddr_i,
        output sb_set_i, sb_set_addr_i, sb_flush_i,
        input  rdata_o, busy_o, stall_o, dbg_inst_o
    );
endinterface

// File: rtl/regfile_fwd_port.sv
// One combinational read port with a priority forwarding network.
// Source priority is forwarding stage 0 (youngest) up to stage NFWD-1, then WB,
// then the array value supplied by the parent.
// Ports:
//   re_i, raddr_i        read enable / address
//   arr_data_i, busy_i   array entry and scoreboard bit for raddr_i
//   fwd_*_i              packed forwarding-stage buses, stage k at [k*W +: W]
//   wb_we_i/waddr/wdata  write-back bypass
//   rdata_o, stall_o     selected data and this port's stall request
module regfile_fwd_port
    import regfile_mp_fwd_pkg::*;
#(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NFWD = 2
) (
    input  logic                re_i,
    input  logic [AW-1:0]       raddr_i,
    input  logic [DW-1:0]       arr_data_i,
    input  logic                busy_i,
    input  logic [NFWD-1:0]     fwd_we_i,
    input  logic [NFWD-1:0]     fwd_valid_i,
    input  logic [NFWD*AW-1:0]  fwd_waddr_i,
    input  logic [NFWD*DW-1:0]  fwd_wdata_i,
    input  logic                wb_we_i,
    input  logic [AW-1:0]       wb_waddr_i,
    input  logic [DW-1:0]       wb_wdata_i,
    output logic [DW-1:0]       rdata_o,
    output logic                stall_o
);

    logic hit;

    always_comb begin
        rdata_o = '0;
        stall_o = 1'b0;
        hit     = 1'b0;
        if (re_i == READ_ENABLE && raddr_i != '0) begin
            // The first matching stage wins outright. An unready producer
            // stalls the port and does not fall through to older data.
            for (int k = 0; k < NFWD; k++) begin
                if (!hit && fwd_we_i[k] && fwd_waddr_i[k*AW +: AW] == raddr_i) begin
                    hit     = 1'b1;
                    rdata_o = fwd_wdata_i[k*DW +: DW];
                    stall_o = ~fwd_valid_i[k];
                end
            end
            // A WB match also satisfies a busy register. This covers the
            // long-op result arriving in this cycle.
            if (!hit && wb_we_i && wb_waddr_i == raddr_i) begin
                hit     = 1'b1;
                rdata_o = wb_wdata_i;
            end
            if (!hit) begin
                rdata_o = arr_data_i;
                stall_o = busy_i;
            end
        end
    end

endmodule

// File: rtl/regfile_mp_fwd.sv
// Parametrised multi-port register file for the ID stage.
// It contains the storage array, a per-register busy scoreboard for multi-cycle
// units, and a debug instruction register. Each of the NRD read ports is a
// regfile_fwd_port instance. stall_o is the OR of the per-port stalls.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset
//   bus   regfile_mp_fwd_if.slave (write-back, forwarding, read, scoreboard, status)
module regfile_mp_fwd
    import regfile_mp_fwd_pkg::*;
#(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2,
    parameter int NFWD = 2
) (
    input  logic          clk,
    input  logic          rst,
    regfile_mp_fwd_if.slave bus
);

    localparam int DEPTH = 2**AW;

    logic [DW-1:0]     regs_q [DEPTH];
    logic [DW-1:0]     regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DW-1:0]     dbg_inst_q, dbg_inst_d;
    logic [NRD-1:0]    port_stall;
    logic [NRD*DW-1:0] port_rdata;
    logic              wb_long_we;

    assign wb_long_we = bus.wb_we_i & bus.wb_long_i;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (bus.wb_we_i == WRITE_ENABLE && bus.wb_waddr_i != '0) begin
            regs_d[bus.wb_waddr_i] = bus.wb_wdata_i;
        end
    end

    // Flush beats everything. A set of the same register beats a long-op
    // completion in the same cycle, so the clear goes first and the set after.
    always_comb begin
        busy_d = busy_q;
        if (bus.sb_flush_i) begin
            busy_d = '0;
        end else begin
            if (wb_long_we) begin
                busy_d[bus.wb_waddr_i] = 1'b0;
            end
            if (bus.sb_set_i && bus.sb_set_addr_i != '0) begin
                busy_d[bus.sb_set_addr_i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    assign dbg_inst_d = bus.wb_inst_i;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RSTN_ENABLE) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            dbg_inst_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q     <= busy_d;
            dbg_inst_q <= dbg_inst_d;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_port
        logic [AW-1:0] raddr;
        logic [DW-1:0] rdata;
        logic          stall;

        assign raddr = bus.raddr_i[p*AW +: AW];

        regfile_fwd_port #(
            .DW   (DW),
            .AW   (AW),
            .NFWD (NFWD)
        ) u_port (
            .re_i        (bus.re_i[p]),
            .raddr_i     (raddr),
            .arr_data_i  (regs_q[raddr]),
            .busy_i      (busy_q[raddr]),
            .fwd_we_i    (bus.fwd_we_i),
            .fwd_valid_i (bus.fwd_valid_i),
            .fwd_waddr_i (bus.fwd_waddr_i),
            .fwd_wdata_i (bus.fwd_wdata_i),
            .wb_we_i     (bus.wb_we_i),
            .wb_waddr_i  (bus.wb_waddr_i),
            .wb_wdata_i  (bus.wb_wdata_i),
            .rdata_o     (rdata),
            .stall_o     (stall)
        );

        assign port_rdata[p*DW +: DW] = rdata;
        assign port_stall[p]          = stall;
    end

    // While reset is held, reads and stall are forced low combinationally.
    // This is independent of any forwarding inputs.
    assign bus.rdata_o    = (rst == RSTN_DISABLE) ? port_rdata : '0;
    assign bus.stall_o    = (rst == RSTN_DISABLE) && (|port_stall);
    assign bus.busy_o     = busy_q;
    assign bus.dbg_inst_o = dbg_inst_q;

endmodule
